// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with programmable wait states,
// word/byte accesses on big-endian lanes, and misalign/range fault reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        byte_sel,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        err
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
    localparam logic [15:0] LIMIT = 16'(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          we_q, bs_q, busy_q, ack_q, err_q;
    logic [15:0]   addr_q, wd_q, rdata_q;
    logic [15:0]   mem_q [DEPTH_WORDS];

    logic          idle, go_resp, cur_we, cur_bs, fault_d;
    logic [15:0]   cur_addr, cur_wd, word, rdata_d, wr_d;
    logic [AW-1:0] idx;

    // With zero wait states RESP is entered straight from IDLE, so the
    // request is taken from the ports rather than the latched copy.
    assign idle     = state_q == S_IDLE;
    assign cur_addr = idle ? addr : addr_q;
    assign cur_we   = idle ? we : we_q;
    assign cur_bs   = idle ? byte_sel : bs_q;
    assign cur_wd   = idle ? wdata : wd_q;
    assign idx      = cur_addr[AW:1];
    assign word     = mem_q[idx];
    assign fault_d  = (!cur_bs && cur_addr[0]) || ({1'b0, cur_addr[15:1]} >= LIMIT);
    assign rdata_d  = (fault_d || cur_we) ? 16'h0000 :
                      !cur_bs ? word :
                      {8'h00, cur_addr[0] ? word[7:0] : word[15:8]};
    assign wr_d     = !cur_bs ? cur_wd :
                      cur_addr[0] ? {word[15:8], cur_wd[7:0]} : {cur_wd[7:0], word[7:0]};
    assign go_resp  = idle ? (req && WAIT_CYCLES == 0) : (state_q == S_WAIT && cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            bs_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (idle && req) begin
                we_q   <= we;
                bs_q   <= byte_sel;
                addr_q <= addr;
                wd_q   <= wdata;
            end
            if (go_resp) begin
                state_q <= S_RESP;
                busy_q  <= 1'b1;
                ack_q   <= 1'b1;
                err_q   <= fault_d;
                rdata_q <= rdata_d;
            end else if (idle && req) begin
                state_q <= S_WAIT;
                cnt_q   <= CNT_INIT;
                busy_q  <= 1'b1;
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 1'b1;
            end else if (state_q == S_RESP) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                ack_q   <= 1'b0;
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    // Stores commit on the edge that ends RESP; a reset on that edge wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else if (state_q == S_RESP && we_q && !err_q) begin
            mem_q[idx] <= wr_d;
        end
    end

    assign busy  = busy_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (2 and 0 wait states) driven in parallel,
// checked by a timing/memory reference model feeding a scoreboard queue.
module tb_dmem_responder;
    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, byte_sel = 1'b0;
    logic [15:0] addr = '0, wdata = '0;
    logic        busy0, ack0, err0, busy1, ack1, err1;
    logic [15:0] rdata0, rdata1;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .byte_sel(byte_sel), .addr(addr),
        .wdata(wdata), .busy(busy0), .ack(ack0), .rdata(rdata0), .err(err0));
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .byte_sel(byte_sel), .addr(addr),
        .wdata(wdata), .busy(busy1), .ack(ack1), .rdata(rdata1), .err(err1));

    typedef struct {
        int          d;
        int          cyc;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0, cyc = 0;
    int          wc[2] = '{2, 0};
    int          bu[2] = '{0, 0};
    logic [15:0] smem [2][256];
    logic        pv[2] = '{1'b0, 1'b0};
    int          pcyc[2];
    logic [15:0] paddr[2], pwd[2];
    logic        pbs[2];
    logic        mf;
    int          mi;
    logic [15:0] mm, mr;
    logic        ma, mb, me;
    logic [15:0] mrd;
    int          mk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: each responder is free again W+2 edges after an
    // accept; the ack is seen W edges later; stores land one edge after that.
    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int i = 0; i < 256; i++) smem[d][i] = 16'h0000;
                pv[d] = 1'b0;
                bu[d] = 0;
                for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].d == d) sb.delete(k);
            end else begin
                if (pv[d] && pcyc[d] == cyc) begin
                    mi = int'(paddr[d] >> 1);
                    mm = smem[d][mi[7:0]];
                    smem[d][mi[7:0]] = !pbs[d] ? pwd[d] :
                        paddr[d][0] ? ((mm & 16'hFF00) | {8'h00, pwd[d][7:0]}) :
                                      ((mm & 16'h00FF) | {pwd[d][7:0], 8'h00});
                    pv[d] = 1'b0;
                end
                if (req && cyc >= bu[d]) begin
                    mi = int'(addr >> 1);
                    mf = (!byte_sel && addr[0]) || mi >= 256;
                    mm = mf ? 16'h0000 : smem[d][mi[7:0]];
                    mr = (mf || we) ? 16'h0000 : !byte_sel ? mm :
                         addr[0] ? {8'h00, mm[7:0]} : {8'h00, mm[15:8]};
                    sb.push_back('{d, cyc + wc[d], mr, mf});
                    bu[d] = cyc + wc[d] + 2;
                    if (we && !mf) begin
                        pv[d] = 1'b1;
                        pcyc[d] = cyc + wc[d] + 1;
                        paddr[d] = addr;
                        pwd[d] = wdata;
                        pbs[d] = byte_sel;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int d = 0; d < 2; d++) begin
                ma  = d == 0 ? ack0 : ack1;
                mb  = d == 0 ? busy0 : busy1;
                me  = d == 0 ? err0 : err1;
                mrd = d == 0 ? rdata0 : rdata1;
                check($sformatf("busy%0d", d), 32'(mb), 32'(cyc < bu[d] - 1));
                mk = -1;
                foreach (sb[i]) if (mk < 0 && sb[i].d == d) mk = i;
                if (ma) begin
                    if (mk < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ack%0d: unexpected ack at cycle %0d", d, cyc);
                    end else begin
                        check($sformatf("ack_cycle%0d", d), cyc, sb[mk].cyc);
                        check($sformatf("rdata%0d", d), 32'(mrd), 32'(sb[mk].rdata));
                        check($sformatf("err%0d", d), 32'(me), 32'(sb[mk].err));
                        sb.delete(mk);
                    end
                end else begin
                    check($sformatf("idle_rdata%0d", d), 32'(mrd), 32'h0);
                    check($sformatf("idle_err%0d", d), 32'(me), 32'h0);
                    if (mk >= 0 && sb[mk].cyc <= cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL ack%0d: missing ack got 0 expected 1 at cycle %0d", d, cyc);
                        sb.delete(mk);
                    end
                end
            end
        end
    end

    task automatic issue(logic w, logic b, logic [15:0] a, logic [15:0] wd, int gap);
        req = 1'b1;
        we = w;
        byte_sel = b;
        addr = a;
        wdata = wd;
        @(posedge clk);
        #2 req = 1'b0;
        repeat (4 + gap) @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2;
        issue(1'b0, 1'b0, 16'h0004, 16'h0000, 0);
        issue(1'b1, 1'b0, 16'h0010, 16'hBEEF, 0);
        issue(1'b0, 1'b0, 16'h0010, 16'h0000, 1);
        issue(1'b0, 1'b1, 16'h0010, 16'h0000, 0);
        issue(1'b0, 1'b1, 16'h0011, 16'h0000, 0);
        issue(1'b1, 1'b1, 16'h0011, 16'h775A, 0);
        issue(1'b0, 1'b0, 16'h0010, 16'h0000, 0);
        issue(1'b0, 1'b0, 16'h0003, 16'h0000, 0);
        issue(1'b0, 1'b0, 16'h0200, 16'h0000, 0);
        issue(1'b1, 1'b0, 16'h0201, 16'hDEAD, 0);
        issue(1'b0, 1'b0, 16'h0010, 16'h0000, 2);
        // Held request: accepts only in IDLE, one ack per accept.
        req = 1'b1;
        we = 1'b0;
        byte_sel = 1'b0;
        for (int i = 0; i < 24; i++) begin
            addr = i[0] ? 16'h0010 : 16'h0020;
            @(posedge clk);
            #2;
        end
        req = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        // Store aborted by a reset during the 2-wait responder's RESP cycle.
        req = 1'b1;
        we = 1'b1;
        byte_sel = 1'b0;
        addr = 16'h0020;
        wdata = 16'h1234;
        @(posedge clk);
        #2 req = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        issue(1'b0, 1'b0, 16'h0020, 16'h0000, 0);
        for (int i = 0; i < 80; i++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0 ? 16'($urandom) : 16'($urandom_range(0, 63)),
                  16'($urandom), $urandom_range(0, 3));
        end
        repeat (10) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
